// File: rtl/alu_ga_stim_gen_if.sv
// ALU input-port bus: one transaction (opcode plus two operands) per valid/ready handshake.
// Valid/ready rules: the master raises valid with stable op/op_a/op_b and keeps them
// unchanged until the edge where valid and ready are both high. That edge is the transfer.
// Ready sampled while valid is low has no effect.
interface alu_ga_stim_gen_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  valid;
   logic                  ready;
   logic [3:0]            op;
   logic [DATA_WIDTH-1:0] op_a;
   logic [DATA_WIDTH-1:0] op_b;

   modport master (output valid, output op, output op_a, output op_b, input ready);
   modport slave  (input valid, input op, input op_a, input op_b, output ready);
endinterface

// File: rtl/alu_ga_stim_gen.sv
// Stimulus generator for the ALU GA environment.
// A Galois LFSR (mask 32'h8020_0003, shifts right) advances one step per drawn transaction.
// The opcode, operand A, operand B and delay fields of the new LFSR state are each folded
// into the chromosome range that was latched at START.
// A run ends after TRANS_COUNT accepted transactions and then holds DONE.
module alu_ga_stim_gen #(
   parameter int          DATA_WIDTH  = 8,
   parameter int          TRANS_COUNT = 200,
   parameter logic [31:0] SEED        = 32'h0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [3:0]            dly_min,
   input  logic [3:0]            dly_max,
   input  logic [DATA_WIDTH-1:0] a_min,
   input  logic [DATA_WIDTH-1:0] a_max,
   input  logic [DATA_WIDTH-1:0] b_min,
   input  logic [DATA_WIDTH-1:0] b_max,
   input  logic [3:0]            op_min,
   input  logic [3:0]            op_max,
   alu_ga_stim_gen_if.master     alu,
   output logic                  busy,
   output logic                  done,
   output logic [15:0]           count,
   output logic [1:0]            fsm_state
);

   // A zero seed would lock the LFSR at zero, so it is replaced by a fixed non-zero value.
   localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'hACE1_ACE1 : SEED;
   localparam logic [31:0] POLY     = 32'h8020_0003;
   localparam logic [15:0] TC16     = 16'(TRANS_COUNT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      SEND  = 2'd2,
      FIN   = 2'd3
   } state_t;

   state_t                state;
   logic [31:0]           lfsr;
   logic [3:0]            dly_cnt;
   logic                  valid_r;
   logic [3:0]            op_r;
   logic [DATA_WIDTH-1:0] op_a_r;
   logic [DATA_WIDTH-1:0] op_b_r;

   // Range inputs as they were captured at the most recent accepted START.
   logic [3:0]            l_dly_min, l_dly_max, l_op_min, l_op_max;
   logic [DATA_WIDTH-1:0] l_a_min, l_a_max, l_b_min, l_b_max;

   // Ranges used by the current draw.
   logic [3:0]            r_dly_min, r_dly_max, r_op_min, r_op_max;
   logic [DATA_WIDTH-1:0] r_a_min, r_a_max, r_b_min, r_b_max;

   logic                  accept_start;
   logic [31:0]           s_draw;
   logic [3:0]            d_op, d_dly;
   logic [DATA_WIDTH-1:0] d_a, d_b;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
   endfunction

   // Computes min + (raw mod span). The sum is formed one bit wider so it cannot wrap,
   // and the result never exceeds max. An empty or inverted range returns min.
   function automatic logic [7:0] map_range(input logic [7:0] raw,
                                            input logic [7:0] mn,
                                            input logic [7:0] mx);
      logic [8:0] span;
      if (mx <= mn) return mn;
      span = {1'b0, mx} - {1'b0, mn} + 9'd1;
      return 8'({1'b0, mn} + ({1'b0, raw} % span));
   endfunction

   assign accept_start = start && ((state == IDLE) || (state == FIN));

   // The first draw of a run uses the incoming ranges directly, because they are latched
   // on that same edge. Every later draw uses the latched copy.
   always_comb begin
      r_dly_min = l_dly_min;
      r_dly_max = l_dly_max;
      r_a_min   = l_a_min;
      r_a_max   = l_a_max;
      r_b_min   = l_b_min;
      r_b_max   = l_b_max;
      r_op_min  = l_op_min;
      r_op_max  = l_op_max;
      if (accept_start) begin
         r_dly_min = dly_min;
         r_dly_max = dly_max;
         r_a_min   = a_min;
         r_a_max   = a_max;
         r_b_min   = b_min;
         r_b_max   = b_max;
         r_op_min  = op_min;
         r_op_max  = op_max;
      end
   end

   // Next LFSR state and the field values folded from it.
   // A new run restarts the LFSR from the seed.
   always_comb begin
      s_draw = lfsr_step(accept_start ? SEED_EFF : lfsr);
      d_a    = DATA_WIDTH'(map_range(8'(s_draw[DATA_WIDTH-1:0]), 8'(r_a_min), 8'(r_a_max)));
      d_b    = DATA_WIDTH'(map_range(8'(s_draw[8 +: DATA_WIDTH]), 8'(r_b_min), 8'(r_b_max)));
      d_op   = 4'(map_range(8'(s_draw[19:16]), 8'(r_op_min), 8'(r_op_max)));
      d_dly  = 4'(map_range(8'(s_draw[27:24]), 8'(r_dly_min), 8'(r_dly_max)));
   end

   // Run control FSM. All outputs are registered. Reset clears every transaction field
   // on the next edge, so no partial transaction stays visible after an abort.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         lfsr      <= 32'h0;
         dly_cnt   <= 4'h0;
         valid_r   <= 1'b0;
         op_r      <= 4'h0;
         op_a_r    <= '0;
         op_b_r    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         count     <= 16'h0;
         l_dly_min <= 4'h0;
         l_dly_max <= 4'h0;
         l_op_min  <= 4'h0;
         l_op_max  <= 4'h0;
         l_a_min   <= '0;
         l_a_max   <= '0;
         l_b_min   <= '0;
         l_b_max   <= '0;
      end else begin
         case (state)
            IDLE, FIN: begin
               if (start) begin
                  l_dly_min <= dly_min;
                  l_dly_max <= dly_max;
                  l_op_min  <= op_min;
                  l_op_max  <= op_max;
                  l_a_min   <= a_min;
                  l_a_max   <= a_max;
                  l_b_min   <= b_min;
                  l_b_max   <= b_max;
                  lfsr      <= s_draw;
                  op_r      <= d_op;
                  op_a_r    <= d_a;
                  op_b_r    <= d_b;
                  dly_cnt   <= d_dly;
                  count     <= 16'h0;
                  done      <= 1'b0;
                  busy      <= 1'b1;
                  state     <= DELAY;
               end
            end
            DELAY: begin
               if (dly_cnt == 4'h0) begin
                  valid_r <= 1'b1;
                  state   <= SEND;
               end else begin
                  dly_cnt <= dly_cnt - 4'h1;
               end
            end
            SEND: begin
               if (alu.ready) begin
                  count   <= count + 16'h1;
                  valid_r <= 1'b0;
                  if (count + 16'h1 == TC16) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= FIN;
                  end else begin
                     lfsr    <= s_draw;
                     op_r    <= d_op;
                     op_a_r  <= d_a;
                     op_b_r  <= d_b;
                     dly_cnt <= d_dly;
                     state   <= DELAY;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign alu.valid = valid_r;
   assign alu.op    = op_r;
   assign alu.op_a  = op_a_r;
   assign alu.op_b  = op_b_r;
   assign fsm_state = state;

endmodule

// File: doc/alu_ga_stim_gen.md
# alu_ga_stim_gen

Hardware stimulus generator for the ALU genetic-algorithm verification environment. It draws ALU transactions from a reproducible 32-bit LFSR. Each field is mapped into a [min,max] range supplied by the current chromosome: operand A, operand B, opcode and inter-transaction delay. Transactions are presented to the ALU input port over a valid/ready handshake. One run produces exactly TRANS_COUNT transactions and then reports completion to the GA controller.

## Interface
- DATA_WIDTH, 8, operand width (1..8); operands taken from low bits of the LFSR slice
- TRANS_COUNT, 200, transactions per run (1..65535)
- SEED, 0, LFSR seed loaded on each START; 0 is replaced by 32'hACE1_ACE1
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous, active-low reset
- START  in  1  one-cycle run request; latches all range inputs
- DLY_MIN, DLY_MAX  in  4 each  delay range in cycles
- A_MIN, A_MAX  in  DATA_WIDTH each  operand A range
- B_MIN, B_MAX  in  DATA_WIDTH each  operand B range
- OP_MIN, OP_MAX  in  4 each  opcode range
- VALID  out  1  transaction present
- READY  in  1  ALU accepts transaction
- OP  out  4  opcode
- OP_A, OP_B  out  DATA_WIDTH each  operands
- BUSY  out  1  run in progress
- DONE  out  1  run complete; held until next START or reset
- COUNT  out  16  transactions accepted in current/last run

## Operation
- States: IDLE, DELAY, SEND, FIN.
- IDLE/FIN + START:
  - latch ranges; LFSR <= seed; COUNT <= 0; DONE <= 0.
  - Draw transaction 0, go to DELAY.
- START in DELAY or SEND is ignored; latched ranges are not updated.
- LFSR: Galois, polynomial x^32+x^22+x^2+x+1, mask 32'h8020_0003, shift right.
  - Advances exactly one step per draw.
  - Transaction k uses S_k, where S_0 = step(seed) and S_{k+1} = step(S_k).
- Field slices of S_k:
  - A from [7:0]
  - B from [15:8]
  - op from [19:16]
  - delay from [27:24]
- Range mapping per field: value = min + (raw mod (max-min+1)).
  - If max <= min, value = min.
  - Arithmetic is one bit wider than the field, so no wrap.
- Draw: fields registered into OP/OP_A/OP_B and the delay counter in the same cycle the LFSR steps.
- DELAY: counter decrements each cycle; go to SEND when it is 0. A drawn delay of 0 spends exactly one cycle in DELAY.
- SEND:
  - VALID = 1; OP/OP_A/OP_B held stable until the handshake.
  - On VALID & READY: COUNT += 1.
  - If new COUNT == TRANS_COUNT, go to FIN with DONE = 1.
  - Otherwise draw the next transaction and go to DELAY.
- FIN: VALID = 0, BUSY = 0, DONE = 1; outputs hold their last values.
- BUSY = 1 in DELAY and SEND.

## Timing
- Reset (RST = 0 at a rising edge):
  - state IDLE, VALID 0, BUSY 0, DONE 0, COUNT 0.
  - OP, OP_A, OP_B = 0; LFSR = 0.
- Reset mid-run aborts immediately; no partial transaction remains visible next cycle.
- START sampled at edge t: BUSY = 1 from t+1; first VALID at t+2+d0.
- Handshake at edge h (not last): VALID = 0 at h+1; next VALID at h+2+d_{k+1}.
- Minimum spacing is therefore 2 cycles per transaction.
- Last handshake at edge h: DONE = 1 and BUSY = 0 from h+1.
- READY while VALID = 0 is ignored.
- READY held high continuously: each transaction is accepted on its first VALID cycle.

## Test plan
- Reset:
  - Stimulus: assert RST = 0 for 3 cycles, with START = 1 held throughout.
  - Required: all outputs 0, state IDLE, no VALID.
- Fixed ranges:
  - Stimulus: all min = max (DLY 0, A 5, B 9, OP 3), READY = 1, TRANS_COUNT = 200.
  - Required: 200 transactions, all OP = 3, A = 5, B = 9, one every 2 cycles.
  - Required: DONE at START + 401; COUNT = 200.
- Delay:
  - Stimulus: DLY_MIN = DLY_MAX = 4, READY = 1.
  - Required: VALID spacing exactly 6 cycles; first VALID at t+6.
- Backpressure:
  - Stimulus: READY low for 10 cycles during SEND.
  - Required: VALID and fields stable for all 10 cycles; COUNT unchanged until READY rises.
- Reproducibility and ranges:
  - Stimulus: SEED = 0, full ranges (A 0..255, OP 0..15, DLY 1..4). Run twice.
  - Required: identical sequences, matching a reference model starting from 32'hACE1_ACE1.
  - Required: every value inside its range.
- Restart and abort:
  - Stimulus 1: START during SEND.
  - Required: ignored.
  - Stimulus 2: RST = 0 after 50 transactions, then START.
  - Required: COUNT restarts at 0 and the sequence repeats from S_0.
